// File: rtl/parity_rx.sv
// parity_rx: serial frame receiver (start, DATA_W bits LSB first, parity, stop).
// Ports:
//   clk, rst_n  - clock and async active-low reset
//   sin         - serial bit, sampled when sin_valid = 1
//   sin_valid   - bit strobe
//   data        - last received word
//   data_valid  - one-cycle pulse per completed frame
//   parity_err  - parity mismatch for the frame marked by data_valid
//   frame_err   - bad stop bit for the frame marked by data_valid
//   busy        - receiver is inside a frame
module parity_rx #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin,
    input  logic              sin_valid,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] shreg;
    logic              par_run;
    logic              par_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = (state != IDLE);
        if (sin_valid) begin
            unique case (state)
                IDLE: if (!sin) state_n = DATA;
                DATA: if (count == LAST) state_n = PAR;
                PAR:  state_n = STOP;
                STOP: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Result registers load on the STOP strobe itself, so a start bit
    // in the following cycle (while data_valid is high) is taken normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            shreg      <= '0;
            par_run    <= 1'b0;
            par_pend   <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (sin_valid) begin
                unique case (state)
                    IDLE: begin
                        if (!sin) begin
                            count   <= '0;
                            par_run <= ODD;
                        end
                    end
                    DATA: begin
                        shreg[count] <= sin;
                        par_run      <= par_run ^ sin;
                        count        <= count + 1'b1;
                    end
                    PAR: begin
                        par_pend <= par_run ^ sin;
                    end
                    STOP: begin
                        data       <= shreg;
                        parity_err <= par_pend;
                        frame_err  <= ~sin;
                        data_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_rx.sv
// tb_parity_rx: scoreboard bench for parity_rx (even instance and odd instance).
// Stimulus pushes expected frames; negedge monitors pop and compare on data_valid.
module tb_parity_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s0 = 1'b1;
    logic       v0 = 1'b0;
    logic       s1 = 1'b1;
    logic       v1 = 1'b0;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       dv0, pe0, fe0, b0;
    logic       dv1, pe1, fe1, b1;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_chk = 0;
    int   n_fail = 0;
    logic pdv0 = 1'b0;
    logic pdv1 = 1'b0;

    always #5 clk = ~clk;

    parity_rx #(.DATA_W(8), .ODD(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .sin(s0), .sin_valid(v0),
        .data(d0), .data_valid(dv0), .parity_err(pe0),
        .frame_err(fe0), .busy(b0)
    );

    parity_rx #(.DATA_W(8), .ODD(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .sin(s1), .sin_valid(v1),
        .data(d1), .data_valid(dv1), .parity_err(pe1),
        .frame_err(fe1), .busy(b1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && dv0) begin
            exp_t e;
            chk("dv0_one_cycle", 32'(pdv0), 32'(0));
            if (q0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dv0_unexpected: got pulse data %0h expected none", d0);
            end else begin
                e = q0.pop_front();
                chk("data0", 32'(d0), 32'(e.d));
                chk("perr0", 32'(pe0), 32'(e.pe));
                chk("ferr0", 32'(fe0), 32'(e.fe));
            end
        end
        pdv0 = dv0;
    end

    always @(negedge clk) begin
        if (rst_n && dv1) begin
            exp_t e;
            chk("dv1_one_cycle", 32'(pdv1), 32'(0));
            if (q1.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL dv1_unexpected: got pulse data %0h expected none", d1);
            end else begin
                e = q1.pop_front();
                chk("data1", 32'(d1), 32'(e.d));
                chk("perr1", 32'(pe1), 32'(e.pe));
                chk("ferr1", 32'(fe1), 32'(e.fe));
            end
        end
        pdv1 = dv1;
    end

    task automatic send_bit(input int u, input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            if (u == 0) s0 = ~s0;
            else s1 = ~s1;
            @(posedge clk);
            #1;
        end
        if (u == 0) begin
            s0 = b;
            v0 = 1'b1;
        end else begin
            s1 = b;
            v1 = 1'b1;
        end
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic send_frame(input int u, input logic [7:0] d,
                              input logic p, input logic stp,
                              input int gap, input logic epe,
                              input logic efe);
        exp_t e;
        e.d  = d;
        e.pe = epe;
        e.fe = efe;
        send_bit(u, 1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(u, d[i], gap);
        send_bit(u, p, gap);
        if (u == 0) q0.push_back(e);
        else q1.push_back(e);
        send_bit(u, stp, gap);
    endtask

    initial begin
        #2;
        chk("rst_data", 32'(d0), 32'(0));
        chk("rst_dv", 32'(dv0), 32'(0));
        chk("rst_perr", 32'(pe0), 32'(0));
        chk("rst_ferr", 32'(fe0), 32'(0));
        chk("rst_busy", 32'(b0), 32'(0));
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send_bit(0, 1'b1, 0);
        send_bit(0, 1'b1, 0);
        chk("idle_busy", 32'(b0), 32'(0));

        send_frame(0, 8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        send_frame(0, 8'h01, 1'b0, 1'b1, 0, 1'b1, 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        send_bit(0, 1'b1, 0);
        chk("stop0_not_start_busy", 32'(b0), 32'(0));

        send_bit(0, 1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 0);
        chk("midframe_busy", 32'(b0), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", 32'(d0), 32'(0));
        chk("arst_dv", 32'(dv0), 32'(0));
        chk("arst_perr", 32'(pe0), 32'(0));
        chk("arst_ferr", 32'(fe0), 32'(0));
        chk("arst_busy", 32'(b0), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(b0), 32'(0));
        send_frame(0, 8'hFF, 1'b0, 1'b1, 0, 1'b0, 1'b0);

        send_frame(1, 8'h00, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        send_frame(1, 8'h00, 1'b0, 1'b1, 1, 1'b1, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'(0));
        chk("q1_drained", 32'(q1.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_rx.md
PARITY_RX -- requirements
Module: parity_rx

Interface
- REQ-001 Parameter DATA_W, default 8, SHALL set the number of data bits per frame (legal range 2..16).
- REQ-002 Parameter ODD, default 0, SHALL select parity sense: 0 = even, 1 = odd.
- REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
- REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
- REQ-005 sin  input  1  SHALL be the serial line bit, sampled only when sin_valid = 1.
- REQ-006 sin_valid  input  1  SHALL be the bit strobe; a cycle with sin_valid = 0 SHALL leave the FSM, counters and shift register unchanged.
- REQ-007 data  output  DATA_W  SHALL hold the last received data word.
- REQ-008 data_valid  output  1  SHALL be a one-cycle pulse marking a completed frame.
- REQ-009 parity_err  output  1  SHALL flag a parity mismatch for the frame marked by data_valid.
- REQ-010 frame_err  output  1  SHALL flag a bad stop bit for the frame marked by data_valid.
- REQ-011 busy  output  1  SHALL be 1 whenever the FSM is not in IDLE.

Function
- REQ-012 Frame format SHALL be: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1), one bit per sin_valid strobe.
- REQ-013 The FSM SHALL have exactly four states: IDLE, DATA, PAR, STOP.
- REQ-014 IDLE: strobe with sin = 0 -> DATA, bit counter cleared, running parity set to ODD; strobe with sin = 1 -> stay in IDLE (line idle).
- REQ-015 DATA: each strobe SHALL write sin into shift-register bit [count], XOR sin into running parity and increment count; the strobe with count = DATA_W-1 -> PAR.
- REQ-016 PAR: strobe SHALL latch pending parity error = running parity XOR sin (1 = mismatch) -> STOP.
- REQ-017 STOP: strobe SHALL latch frame error = NOT sin -> IDLE; a 0 stop bit SHALL NOT be taken as a new start bit.
- REQ-018 On the clock edge after the STOP strobe, data SHALL load the shift register, parity_err and frame_err SHALL load the pending flags, and data_valid SHALL be 1 for exactly that one cycle.
- REQ-019 data, parity_err and frame_err SHALL hold their values until the next data_valid pulse.
- REQ-020 A frame with parity or stop errors SHALL still produce data_valid with the received bits on data.
- REQ-021 A start strobe arriving in the cycle data_valid is high SHALL be accepted without loss.
- REQ-022 Minimum frame length SHALL be DATA_W+3 strobes; strobes may be arbitrarily spaced, including back-to-back every cycle.

Reset
- REQ-023 rst_n = 0 SHALL immediately force state = IDLE, count = 0, shift register = 0, data = 0, data_valid = 0, parity_err = 0, frame_err = 0, busy = 0, regardless of clk.
- REQ-024 Reset asserted mid-frame SHALL discard the partial frame; no data_valid SHALL follow reset release until a complete new frame is received.
- REQ-025 The first strobe after reset release SHALL be evaluated as in IDLE.

Verification
- REQ-026 Even parity, back-to-back strobes: 0, bits of 0xA5 LSB first, parity 0, stop 1 -> data = 0xA5, data_valid one cycle, parity_err = 0, frame_err = 0.
- REQ-027 Parity error: frame for 0x01 with parity bit 0 -> data = 0x01, parity_err = 1, frame_err = 0.
- REQ-028 Framing error: frame for 0x3C, correct parity 0, stop 0 -> data = 0x3C, frame_err = 1; the next strobe with sin = 1 leaves busy = 0.
- REQ-029 Gapped strobes: 0x5A sent with sin_valid high one cycle in four, and sin toggled while sin_valid = 0 -> data = 0x5A, no errors.
- REQ-030 Reset mid-frame: rst_n low after 4 data bits -> all outputs 0 asynchronously; a following full 0xFF frame (parity 0) -> data = 0xFF, no errors.
- REQ-031 ODD = 1: frame 0x00 with parity 1 -> parity_err = 0; same frame with parity 0 -> parity_err = 1.
